// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FIFO-to-AXI4-Stream drain engine.
package fifo_axis_pkg;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_AXIS_WIDTH = 32;
  localparam int BEATS          = DEF_DATA_WIDTH / DEF_AXIS_WIDTH;

  typedef logic [DEF_AXIS_WIDTH-1:0] beat_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  typedef enum logic [0:0] {
    PKT_IDLE = 1'b0,
    PKT_OPEN = 1'b1
  } pkt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one FIFO word and emits it as MSB-first stream beats.
module word_serializer #(
  parameter int DATA_WIDTH = fifo_axis_pkg::DEF_DATA_WIDTH,
  parameter int AXIS_WIDTH = fifo_axis_pkg::DEF_AXIS_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  free,
  output logic [AXIS_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  last_beat,
  output logic                  last_beat_fire,
  output logic                  hold_valid
);
  import fifo_axis_pkg::*;

  localparam int NUM_BEATS = DATA_WIDTH / AXIS_WIDTH;
  localparam int BCW       = cnt_w(NUM_BEATS);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NUM_BEATS - 1);

  logic [NUM_BEATS-1:0][AXIS_WIDTH-1:0] hold_q_r;
  logic                                 hold_valid_r;
  logic [BCW-1:0]                       beat_cnt_r;

  logic           fire_s;
  logic           last_beat_s;
  logic           last_fire_s;
  logic [BCW-1:0] beat_idx_s;

  // Handshake decode and MSB-first beat selection.
  always_comb begin
    fire_s      = hold_valid_r & tready;
    last_beat_s = (beat_cnt_r == LAST_BEAT);
    last_fire_s = fire_s & last_beat_s;
    beat_idx_s  = LAST_BEAT - beat_cnt_r;
  end

  // Holding register, its valid flag and the beat position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q_r     <= '0;
      hold_valid_r <= 1'b0;
      beat_cnt_r   <= '0;
    end else begin
      if (load) begin
        hold_q_r     <= load_data;
        hold_valid_r <= 1'b1;
      end else if (last_fire_s) begin
        hold_valid_r <= 1'b0;
      end
      // Position only moves on a handshake, which keeps tdata stable under stall.
      if (fire_s) begin
        beat_cnt_r <= last_beat_s ? '0 : beat_cnt_r + BCW'(1);
      end
    end
  end

  assign tdata          = hold_q_r[beat_idx_s];
  assign tvalid         = hold_valid_r;
  assign hold_valid     = hold_valid_r;
  assign last_beat      = hold_valid_r & last_beat_s;
  assign last_beat_fire = last_fire_s;
  assign free           = ~hold_valid_r | last_fire_s;

endmodule

// File: rtl/fifo_axis_tx.sv
// FIFO read-side drain: pops 128-bit words and streams them as AXIS beats in packets.
module fifo_axis_tx #(
  parameter int DATA_WIDTH = fifo_axis_pkg::DEF_DATA_WIDTH,
  parameter int AXIS_WIDTH = fifo_axis_pkg::DEF_AXIS_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  input  logic                  fifo_ready,
  output logic                  fifo_read_e,
  input  logic [CNT_WIDTH-1:0]  pkt_blocks,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy
);
  import fifo_axis_pkg::*;

  pkt_state_t           state_r, state_n_s;
  logic [CNT_WIDTH-1:0] pkt_len_r, pkt_len_n_s;
  logic [CNT_WIDTH-1:0] blk_cnt_r, blk_cnt_n_s;

  logic                  free_s;
  logic                  pop_s;
  logic                  tvalid_s;
  logic [AXIS_WIDTH-1:0] tdata_s;
  logic                  last_beat_s;
  logic                  last_fire_s;
  logic                  hold_valid_s;
  logic                  tlast_s;
  logic                  tlast_fire_s;
  logic [CNT_WIDTH-1:0]  pkt_len_s;

  word_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .AXIS_WIDTH(AXIS_WIDTH)
  ) u_ser (
    .clk            (clk),
    .reset          (reset),
    .load           (pop_s),
    .load_data      (fifo_rdata),
    .free           (free_s),
    .tdata          (tdata_s),
    .tvalid         (tvalid_s),
    .tready         (m_axis_tready),
    .last_beat      (last_beat_s),
    .last_beat_fire (last_fire_s),
    .hold_valid     (hold_valid_s)
  );

  // Pop decision and packet-boundary decode; reset gating keeps the strobe quiet in reset.
  always_comb begin
    pop_s        = reset & ~fifo_empty & fifo_ready & free_s;
    pkt_len_s    = (pkt_blocks == '0) ? CNT_WIDTH'(1) : pkt_blocks;
    tlast_s      = last_beat_s & (state_r == PKT_OPEN) &
                   (blk_cnt_r == pkt_len_r - CNT_WIDTH'(1));
    tlast_fire_s = tlast_s & m_axis_tready;
  end

  // Packet FSM next state: open on the first pop, close on the tlast handshake.
  always_comb begin
    state_n_s   = state_r;
    pkt_len_n_s = pkt_len_r;
    blk_cnt_n_s = blk_cnt_r;
    case (state_r)
      PKT_IDLE: begin
        if (pop_s) begin
          state_n_s   = PKT_OPEN;
          pkt_len_n_s = pkt_len_s;
          blk_cnt_n_s = '0;
        end else begin
          state_n_s = PKT_IDLE;
        end
      end
      PKT_OPEN: begin
        if (tlast_fire_s) begin
          blk_cnt_n_s = '0;
          // A pop on the closing handshake starts the next packet immediately.
          if (pop_s) begin
            state_n_s   = PKT_OPEN;
            pkt_len_n_s = pkt_len_s;
          end else begin
            state_n_s = PKT_IDLE;
          end
        end else if (last_fire_s) begin
          blk_cnt_n_s = blk_cnt_r + CNT_WIDTH'(1);
        end else begin
          blk_cnt_n_s = blk_cnt_r;
        end
      end
      default: begin
        state_n_s   = PKT_IDLE;
        pkt_len_n_s = CNT_WIDTH'(1);
        blk_cnt_n_s = '0;
      end
    endcase
  end

  // Packet FSM state, latched length and block counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= PKT_IDLE;
      pkt_len_r <= CNT_WIDTH'(1);
      blk_cnt_r <= '0;
    end else begin
      state_r   <= state_n_s;
      pkt_len_r <= pkt_len_n_s;
      blk_cnt_r <= blk_cnt_n_s;
    end
  end

  assign fifo_read_e   = pop_s;
  assign m_axis_tdata  = tdata_s;
  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tlast  = tlast_s;
  assign busy          = hold_valid_s | (state_r == PKT_OPEN);

endmodule

// File: tb/tb_fifo_axis_tx.sv
// Scoreboard bench for fifo_axis_tx: FIFO model driver plus an independent stream monitor.
module tb_fifo_axis_tx;
  import fifo_axis_pkg::*;

  typedef struct packed {
    logic  last;
    beat_t data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  word_t       fifo_rdata;
  logic        fifo_empty;
  logic        fifo_ready;
  logic        fifo_read_e;
  logic [15:0] pkt_blocks;
  beat_t       m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;

  exp_t  exp_q[$];
  word_t fifo_q[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    pop_cnt = 0;
  int    tb_blk = 0;
  int    tb_len = 1;
  bit    rand_ready = 1'b0;

  always #5 clk = ~clk;

  fifo_axis_tx dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_ready    (fifo_ready),
    .fifo_read_e   (fifo_read_e),
    .pkt_blocks    (pkt_blocks),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fifo_upd();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Push a word into the FIFO model; optionally derive its expected beats from the packet model.
  task automatic push_word(input word_t w, input bit gen_exp);
    bit   last_blk;
    exp_t e;
    fifo_q.push_back(w);
    if (gen_exp) begin
      if (tb_blk == 0) tb_len = (pkt_blocks == 16'd0) ? 1 : int'(pkt_blocks);
      last_blk = (tb_blk == tb_len - 1);
      tb_blk   = last_blk ? 0 : tb_blk + 1;
      for (int k = 0; k < 4; k++) begin
        e.data = w[127 - 32*k -: 32];
        e.last = last_blk && (k == 3);
        exp_q.push_back(e);
      end
    end
    fifo_upd();
  endtask

  // One clock: note whether the DUT pops before the edge, retire it from the FIFO model afterwards.
  task automatic cyc();
    logic p;
    #2;
    p = fifo_read_e;
    if (p) pop_cnt++;
    @(negedge clk);
    if (p && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (rand_ready) m_axis_tready = ($urandom_range(0, 1) == 1);
    fifo_upd();
  endtask

  task automatic drain(input string name, input int limit, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      cyc();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Monitor: scoreboard compare on every handshake, plus stall stability and pop-rule checks.
  always @(negedge clk) begin : mon
    static int   mon_beat = 0;
    static bit   prev_stall = 1'b0;
    static exp_t prev_beat = '0;
    exp_t e;
    #3;
    if (!reset) begin
      mon_beat   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1);
        chk("stall_stable", {m_axis_tlast, m_axis_tdata}, prev_beat);
      end
      if (fifo_read_e)
        chk("pop_rule", (!m_axis_tvalid || (m_axis_tready && mon_beat == 3)), 1);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {m_axis_tlast, m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_axis_tlast, m_axis_tdata}, e);
        end
        mon_beat = (mon_beat + 1) % 4;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    n;
    word_t w;
    exp_t  e;
    reset = 1'b0; fifo_ready = 1'b1; m_axis_tready = 1'b1; pkt_blocks = 16'd1;
    fifo_upd();
    @(negedge clk);

    // Reset with an empty FIFO, then idle after release.
    #1 chk("rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_read_e, busy}, 0);
    repeat (3) cyc();
    chk("rst_no_pop", pop_cnt, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      #1 chk("idle_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_read_e, busy}, 0);
    end
    cyc();
    chk("idle_no_pop", pop_cnt, 0);

    // Single directed word, 1-block packet.
    pop_cnt = 0; pkt_blocks = 16'd1;
    w = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    push_word(w, 1'b0);
    e.last = 1'b0; e.data = 32'h00112233; exp_q.push_back(e);
    e.last = 1'b0; e.data = 32'h44556677; exp_q.push_back(e);
    e.last = 1'b0; e.data = 32'h8899AABB; exp_q.push_back(e);
    e.last = 1'b1; e.data = 32'hCCDDEEFF; exp_q.push_back(e);
    #1 chk("t2_pop_now", fifo_read_e, 1);
    chk("t2_tvalid_pre", m_axis_tvalid, 0);
    drain("t2", 20, n);
    chk("t2_cycles", n, 5);
    chk("t2_pops", pop_cnt, 1);
    chk("t2_busy", busy, 0);

    // Eight preloaded words, 3-block packets, gap-free; ninth word closes the packet.
    pkt_blocks = 16'd3;
    for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drain("t3", 100, n);
    chk("t3_cycles", n, 33);
    chk("t3_open_busy", busy, 1);
    chk("t3_no_tlast_pending", m_axis_tlast, 0);
    push_word(128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE, 1'b1);
    drain("t3b", 20, n);
    chk("t3b_cycles", n, 5);
    chk("t3_busy", busy, 0);

    // Random backpressure, 50 words in 5-block packets.
    pkt_blocks = 16'd5; rand_ready = 1'b1;
    for (int i = 0; i < 50; i++) push_word({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    drain("t4", 3000, n);
    rand_ready = 1'b0; m_axis_tready = 1'b1;
    chk("t4_busy", busy, 0);

    // fifo_ready low: held word finishes, nothing else pops until it rises.
    pkt_blocks = 16'd2;
    push_word(128'h11111111_22222222_33333333_44444444, 1'b1);
    cyc();
    fifo_ready = 1'b0;
    push_word(128'h55555555_66666666_77777777_88888888, 1'b1);
    n = 0;
    while (exp_q.size() > 4 && n < 20) begin cyc(); n++; end
    chk("t5_held_done", exp_q.size(), 4);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_tvalid_off", m_axis_tvalid, 0);
      chk("t5_no_pop", fifo_read_e, 0);
      cyc();
    end
    chk("t5_fifo_kept", fifo_q.size(), 1);
    fifo_ready = 1'b1;
    #1 chk("t5_pop_resume", fifo_read_e, 1);
    drain("t5", 20, n);
    chk("t5_busy", busy, 0);

    // Reset mid-packet, then a 1-block packet from pkt_blocks=0.
    pkt_blocks = 16'd2;
    push_word(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b1);
    push_word(128'hE4E4E4E4_F5F5F5F5_06060606_17171717, 1'b1);
    n = 0;
    while (exp_q.size() > 6 && n < 20) begin cyc(); n++; end
    chk("t6_two_beats", exp_q.size(), 6);
    reset = 1'b0;
    #1 chk("t6_rst_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_read_e, busy}, 0);
    fifo_q.delete(); exp_q.delete(); tb_blk = 0;
    fifo_upd();
    cyc(); cyc();
    reset = 1'b1; pkt_blocks = 16'd0;
    push_word(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
    drain("t6", 20, n);
    chk("t6_cycles", n, 5);
    chk("t6_busy", busy, 0);

    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
